// File: rtl/taxi_input_cond_if.sv
// taxi_input_cond_if: raw sensor pins in, clean strobes and trip state out
interface taxi_input_cond_if;
    logic        pulse_port;
    logic        stat_port;
    logic        pulse_tick;
    logic        stat_tick;
    logic [1:0]  run_state;
    logic [15:0] pulse_cnt;
    logic        stalled;
    modport master(output pulse_port, stat_port, input pulse_tick, stat_tick, run_state, pulse_cnt, stalled);
    modport slave(input pulse_port, stat_port, output pulse_tick, stat_tick, run_state, pulse_cnt, stalled);
endinterface

// File: rtl/taxi_input_cond.sv
// taxi_input_cond: synchronise/filter wheel pulse and mode key, run trip FSM, count pulses, flag stall
module taxi_input_cond #(
    parameter int PULSE_FILT   = 250,
    parameter int DEB_CYCLES   = 1_000_000,
    parameter int STALL_CYCLES = 50_000_000
) (
    input logic sys_clk,
    input logic sys_rst,
    taxi_input_cond_if.slave bus
);
    localparam int PW = $clog2(PULSE_FILT);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam int TW = $clog2(STALL_CYCLES + 1);

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} state_t;

    state_t state, state_n;
    logic p_s1, p_s2, p_filt, p_done;
    logic k_s1, k_s2, k_filt, k_done;
    logic [PW-1:0] p_cnt;
    logic [DW-1:0] k_cnt;
    logic [TW-1:0] timer, timer_n;

    assign p_done = p_s2 != p_filt && p_cnt == PW'(PULSE_FILT - 1);
    assign k_done = k_s2 != k_filt && k_cnt == DW'(DEB_CYCLES - 1);
    assign bus.run_state = state;

    // key side idles high (released), so a key held through reset still reads as a press
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            p_s1 <= 1'b0;
            p_s2 <= 1'b0;
            p_filt <= 1'b0;
            p_cnt <= '0;
            k_s1 <= 1'b1;
            k_s2 <= 1'b1;
            k_filt <= 1'b1;
            k_cnt <= '0;
            bus.pulse_tick <= 1'b0;
            bus.stat_tick <= 1'b0;
        end else begin
            p_s1 <= bus.pulse_port;
            p_s2 <= p_s1;
            p_cnt <= (p_s2 == p_filt || p_done) ? '0 : p_cnt + 1'b1;
            p_filt <= p_done ? p_s2 : p_filt;
            bus.pulse_tick <= p_done && p_s2;
            k_s1 <= bus.stat_port;
            k_s2 <= k_s1;
            k_cnt <= (k_s2 == k_filt || k_done) ? '0 : k_cnt + 1'b1;
            k_filt <= k_done ? k_s2 : k_filt;
            bus.stat_tick <= k_done && !k_s2;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        timer_n = '0;
        if (bus.stat_tick) state_n = state == IDLE ? RUN : state == RUN ? PAUSE : IDLE;
        if (state == RUN && !bus.pulse_tick)
            timer_n = timer == TW'(STALL_CYCLES) ? timer : timer + 1'b1;
    end

    // count decision uses the pre-edge state, so a pulse coinciding with the pause press still counts
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            bus.pulse_cnt <= '0;
            timer <= '0;
            bus.stalled <= 1'b0;
        end else begin
            bus.pulse_cnt <= (bus.stat_tick && state == IDLE) ? '0 :
                             (bus.pulse_tick && state == RUN && bus.pulse_cnt != 16'hFFFF) ? bus.pulse_cnt + 1'b1 :
                             bus.pulse_cnt;
            timer <= timer_n;
            bus.stalled <= state_n == RUN && timer_n == TW'(STALL_CYCLES);
        end
    end
endmodule
